button_pulser: RTL and testbench

BUTTON_PULSER -- requirements
Module: button_pulser

---
 rtl/btn_pkg.sv | 26 ++
 rtl/btn_debounce_channel.sv | 104 ++++++++++
 rtl/button_pulser.sv | 47 ++++
 tb/tb_button_pulser.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the button pulser: bit map, channel count and default timing.
// Auto-repeat is compiled in only when BTN_AUTOREPEAT_EN is defined.
package btn_pkg;

    localparam int unsigned NUM_BTN = 5;

    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_L = 1;
    localparam int unsigned BTN_R = 2;
    localparam int unsigned BTN_U = 3;
    localparam int unsigned BTN_D = 4;

    localparam int unsigned DEF_DEBOUNCE_MS      = 20;
    localparam int unsigned DEF_REPEAT_DELAY_MS  = 500;
    localparam int unsigned DEF_REPEAT_PERIOD_MS = 100;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold max_val without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button: 2-flop synchroniser, saturating debounce counter, accepted level and press pulse.
// Under BTN_AUTOREPEAT_EN a held press also emits repeat pulses when REPEAT_EN is set.
module btn_debounce_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS      = DEF_DEBOUNCE_MS,
    parameter int unsigned REPEAT_DELAY_MS  = DEF_REPEAT_DELAY_MS,
    parameter int unsigned REPEAT_PERIOD_MS = DEF_REPEAT_PERIOD_MS
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter bit          REPEAT_EN        = 1'b1
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic pulse,
    output logic level
);

    localparam int unsigned CW =
        cnt_width(max2(max2(DEBOUNCE_MS, REPEAT_DELAY_MS), REPEAT_PERIOD_MS));
    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [CW-1:0] DEB_TARGET = CW'(DEBOUNCE_MS);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          differ, toggle, press;

    always_comb begin
        differ  = (s2_q != level_q);
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        toggle  = differ && (cnt_inc == DEB_TARGET);
        press   = toggle && !level_q;
        level_d = level_q ^ toggle;
        cnt_d   = (differ && !toggle) ? cnt_inc : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= btn_raw;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned   RW        = cnt_width(max2(REPEAT_DELAY_MS, REPEAT_PERIOD_MS));
    localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY_MS);
    localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD_MS);

    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc;
    logic          rpt_first_q, rpt_first_d;
    logic          rpt_fire;

    // Repeats stop on the edge the release is accepted, even if a repeat was due.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        rpt_fire    = 1'b0;
        rpt_inc     = rpt_cnt_q + RW'(1);
        if (press) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
        end else if (REPEAT_EN && level_q && !toggle) begin
            if (rpt_inc == (rpt_first_q ? RPT_FIRST : RPT_NEXT)) begin
                rpt_fire    = 1'b1;
                rpt_cnt_d   = '0;
                rpt_first_d = 1'b0;
            end else begin
                rpt_cnt_d = rpt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end

    assign pulse_d = press | rpt_fire;
`else
    assign pulse_d = press;
`endif

    assign pulse = pulse_q;
    assign level = level_q;

endmodule

// File: rtl/button_pulser.sv
// Five debounced push-buttons turned into single-cycle press pulses plus debounced levels.
// Define BTN_AUTOREPEAT_EN to add auto-repeat on L/R/U/D.
module button_pulser
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS      = DEF_DEBOUNCE_MS,
    parameter int unsigned REPEAT_DELAY_MS  = DEF_REPEAT_DELAY_MS,
    parameter int unsigned REPEAT_PERIOD_MS = DEF_REPEAT_PERIOD_MS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic               btnC,
    output logic               btnL,
    output logic               btnR,
    output logic               btnU,
    output logic               btnD,
    output logic [NUM_BTN-1:0] btn_level
);

    logic [NUM_BTN-1:0] pulse;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_debounce_channel #(
            .DEBOUNCE_MS      (DEBOUNCE_MS),
            .REPEAT_DELAY_MS  (REPEAT_DELAY_MS),
            .REPEAT_PERIOD_MS (REPEAT_PERIOD_MS)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_EN        (i != BTN_C)
`endif
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_raw (btn_in[i]),
            .pulse   (pulse[i]),
            .level   (btn_level[i])
        );
    end

    assign btnC = pulse[BTN_C];
    assign btnL = pulse[BTN_L];
    assign btnR = pulse[BTN_R];
    assign btnU = pulse[BTN_U];
    assign btnD = pulse[BTN_D];

endmodule

// File: tb/tb_button_pulser.sv
// Bench for button_pulser: window-based reference model of debounce/press/repeat behaviour.
module tb_button_pulser;

    localparam int DEB  = 20;
    localparam int RD   = 500;
    localparam int RP   = 100;
    localparam int HMAX = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn_in = '0;
    logic       btnC, btnL, btnR, btnU, btnD;
    logic [4:0] btn_level;
    logic [4:0] pulses;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: raw value sampled at each post-reset edge, accepted levels, last events.
    logic [4:0] hist [HMAX];
    int         k;
    int         last_tog [5];
    int         press_k [5];
    logic [4:0] exp_lvl, exp_pulse;

    always #5 clk = ~clk;

    assign pulses = {btnD, btnU, btnR, btnL, btnC};

    button_pulser #(
        .DEBOUNCE_MS      (DEB),
        .REPEAT_DELAY_MS  (RD),
        .REPEAT_PERIOD_MS (RP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .btnC      (btnC),
        .btnL      (btnL),
        .btnR      (btnR),
        .btnU      (btnU),
        .btnD      (btnD),
        .btn_level (btn_level)
    );

    task automatic model_reset();
        k = 0;
        exp_lvl = '0;
        exp_pulse = '0;
        for (int b = 0; b < 5; b++) begin
            last_tog[b] = -100000;
            press_k[b]  = -100000;
        end
    endtask

    // A level is accepted once the synchronised input has differed from it for DEB
    // consecutive edges since the previous acceptance. s2 before edge j is raw at edge j-2.
    task automatic step(input logic [4:0] raw);
        bit   settle;
        logic s2v;
        btn_in = raw;
        @(posedge clk);
        if (k < HMAX - 1) k++;
        hist[k] = raw;
        exp_pulse = '0;
        for (int b = 0; b < 5; b++) begin
            settle = (k - last_tog[b] >= DEB);
            for (int j = k - DEB + 1; j <= k; j++) begin
                s2v = (j >= 3) ? hist[j-2][b] : 1'b0;
                if (s2v == exp_lvl[b]) settle = 0;
            end
            if (settle) begin
                exp_lvl[b] = ~exp_lvl[b];
                last_tog[b] = k;
                if (exp_lvl[b]) begin
                    exp_pulse[b] = 1'b1;
                    press_k[b] = k;
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (b != 0 && exp_lvl[b] && (k - press_k[b]) >= RD &&
                     ((k - press_k[b] - RD) % RP) == 0) begin
                exp_pulse[b] = 1'b1;
            end
`endif
        end
        #1;
    endtask

    task automatic apply_reset(input logic [4:0] raw);
        rst_n = 1'b0;
        btn_in = raw;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn_in = 5'h1f;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (pulses !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_pulses: got %b want 00000", pulses);
        end
        tests_run++;
        if (btn_level !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_level: got %b want 00000", btn_level);
        end
    endtask

    task automatic test_press();
        logic [4:0] raw;
        int         cnt_c = 0;
        apply_reset('0);
        for (int i = 1; i <= 70; i++) begin
            raw = (i >= 10 && i <= 40) ? 5'b00001 : 5'b00000;
            step(raw);
            if (btnC === 1'b1) cnt_c++;
            tests_run++;
            if (pulses !== exp_pulse || btn_level !== exp_lvl) begin
                tests_failed++;
                $display("FAIL press edge %0d: got p=%b l=%b want p=%b l=%b",
                         k, pulses, btn_level, exp_pulse, exp_lvl);
            end
            if (k == 30 || k == 31) begin
                tests_run++;
                if (btnC !== (k == 31) || btn_level[0] !== (k == 31)) begin
                    tests_failed++;
                    $display("FAIL press_latency edge %0d: got btnC=%b lvl=%b want %b",
                             k, btnC, btn_level[0], (k == 31));
                end
            end
        end
        tests_run++;
        if (cnt_c != 1) begin
            tests_failed++;
            $display("FAIL press_count: got %0d want 1", cnt_c);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] raw;
        int         cnt_l = 0;
        int         lvl_hi = 0;
        apply_reset('0);
        for (int i = 1; i <= 70; i++) begin
            if (i >= 3 && i < 8) raw = 5'b00010;
            else if (i >= 11 && i < 30) raw = 5'b00010;
            else raw = 5'b00000;
            step(raw);
            if (btnL === 1'b1) cnt_l++;
            if (btn_level[1] !== 1'b0) lvl_hi++;
            tests_run++;
            if (pulses !== exp_pulse || btn_level !== exp_lvl) begin
                tests_failed++;
                $display("FAIL bounce edge %0d: got p=%b l=%b want p=%b l=%b",
                         k, pulses, btn_level, exp_pulse, exp_lvl);
            end
        end
        tests_run++;
        if (cnt_l != 0 || lvl_hi != 0) begin
            tests_failed++;
            $display("FAIL bounce_filter: got pulses=%0d level_hi=%0d want 0 0", cnt_l, lvl_hi);
        end
    endtask

    task automatic test_simultaneous();
        int both = 0;
        int other = 0;
        apply_reset('0);
        for (int i = 1; i <= 70; i++) begin
            step((i >= 4 && i < 34) ? 5'b10100 : 5'b00000);
            if (pulses === 5'b10100) both++;
            else if (pulses !== 5'b00000) other++;
            tests_run++;
            if (pulses !== exp_pulse || btn_level !== exp_lvl) begin
                tests_failed++;
                $display("FAIL simul edge %0d: got p=%b l=%b want p=%b l=%b",
                         k, pulses, btn_level, exp_pulse, exp_lvl);
            end
        end
        tests_run++;
        if (both != 1 || other != 0) begin
            tests_failed++;
            $display("FAIL simul_same_cycle: got joint=%0d other=%0d want 1 0", both, other);
        end
    endtask

    task automatic test_reset_mid_press();
        int first_pulse = -1;
        apply_reset('0);
        for (int i = 1; i <= 24; i++) step((i >= 10) ? 5'b01000 : 5'b00000);
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if (pulses !== 5'b0 || btn_level !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_debounce: got p=%b l=%b want 0 0", pulses, btn_level);
        end
        apply_reset(5'b01000);
        for (int i = 1; i <= 22; i++) begin
            step(5'b01000);
            if (btnU === 1'b1 && first_pulse < 0) first_pulse = k;
            tests_run++;
            if (pulses !== exp_pulse || btn_level !== exp_lvl) begin
                tests_failed++;
                $display("FAIL held_reset edge %0d: got p=%b l=%b want p=%b l=%b",
                         k, pulses, btn_level, exp_pulse, exp_lvl);
            end
        end
        tests_run++;
        if (first_pulse != 22) begin
            tests_failed++;
            $display("FAIL held_reset_latency: got edge %0d want 22", first_pulse);
        end
        // btnU is high right now; reset must drop it without waiting for a clock edge.
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if (pulses !== 5'b0 || btn_level !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_pulse: got p=%b l=%b want 0 0", pulses, btn_level);
        end
    endtask

    task automatic test_random();
        logic [4:0] raw = '0;
        apply_reset('0);
        for (int i = 1; i <= 800; i++) begin
            for (int b = 0; b < 5; b++) raw[b] = raw[b] ^ ($urandom_range(15, 0) == 0);
            step(raw);
            tests_run++;
            if (pulses !== exp_pulse || btn_level !== exp_lvl) begin
                tests_failed++;
                $display("FAIL random edge %0d: got p=%b l=%b want p=%b l=%b",
                         k, pulses, btn_level, exp_pulse, exp_lvl);
            end
        end
    endtask

    task automatic test_autorepeat();
        int cnt_u = 0;
        int cnt_c = 0;
        int want_u;
`ifdef BTN_AUTOREPEAT_EN
        want_u = 7;
`else
        want_u = 1;
`endif
        apply_reset('0);
        for (int i = 1; i <= 1052; i++) begin
            step((i >= 3 && i < 1013) ? 5'b01001 : 5'b00000);
            if (btnU === 1'b1) cnt_u++;
            if (btnC === 1'b1) cnt_c++;
            tests_run++;
            if (pulses !== exp_pulse || btn_level !== exp_lvl) begin
                tests_failed++;
                $display("FAIL hold edge %0d: got p=%b l=%b want p=%b l=%b",
                         k, pulses, btn_level, exp_pulse, exp_lvl);
            end
        end
        tests_run++;
        if (cnt_u != want_u || cnt_c != 1) begin
            tests_failed++;
            $display("FAIL hold_counts: got U=%0d C=%0d want U=%0d C=1", cnt_u, cnt_c, want_u);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid_press();
        test_random();
        test_autorepeat();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
